// File: rtl/spi_pkg.sv
// Shared types and default sizes for the SPI serial-to-parallel receive path.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HEAD = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int HEAD_W_DEF  = 2;
    localparam int DATA_W_DEF  = 14;
    localparam int FRAME_W_DEF = HEAD_W_DEF + DATA_W_DEF;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_s2p_if.sv
// SPI pad signals plus the parallel receive outputs, bundled as one bus.
interface spi_s2p_if #(
    parameter int HEAD_W = spi_pkg::HEAD_W_DEF,
    parameter int DATA_W = spi_pkg::DATA_W_DEF
);
    logic              sck;
    logic              cs;
    logic              mosi;
    logic              head_flag;
    logic [HEAD_W-1:0] cmd_out;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              frame_err;
    logic              busy;

    modport slave (
        input  sck, cs, mosi,
        output head_flag, cmd_out, data_out, data_valid, frame_err, busy
    );

    modport master (
        output sck, cs, mosi,
        input  head_flag, cmd_out, data_out, data_valid, frame_err, busy
    );

endinterface

// File: rtl/sync_edge.sv
// Multi-stage synchroniser for an asynchronous input with edge detection on
// the synchronised level; reset value matches the line's idle state.
module sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              prev_q;
    logic              prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_in};
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    // Edges compare two flopped copies, so no input reaches these outputs combinationally.
    assign level = sync_q[STAGES-1];
    assign rise  = sync_q[STAGES-1] & ~prev_q;
    assign fall  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_s2p.sv
// SPI mode-0 slave receive path: oversamples sck/cs/mosi in the clk domain and
// deserialises each frame into a header (command) field and a data word.
module spi_s2p
    import spi_pkg::*;
#(
    parameter int HEAD_W      = HEAD_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic     clk,
    input  logic     rst,
    spi_s2p_if.slave bus
);

    localparam int FRAME_W = HEAD_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    // Only the widest field ever has to be reassembled, so the shifter is one bit shorter than it.
    localparam int SHIFT_W = max_int(HEAD_W, DATA_W) - 1;

    logic sck_rise;
    logic cs_rise;
    logic cs_fall;
    logic mosi_s;
    logic sck_level_unused;
    logic sck_fall_unused;
    logic cs_level_unused;
    logic mosi_rise_unused;
    logic mosi_fall_unused;

    sync_edge #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b0)
    ) u_sync_sck (
        .clk   (clk),
        .rst   (rst),
        .d_in  (bus.sck),
        .level (sck_level_unused),
        .rise  (sck_rise),
        .fall  (sck_fall_unused)
    );

    sync_edge #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sync_cs (
        .clk   (clk),
        .rst   (rst),
        .d_in  (bus.cs),
        .level (cs_level_unused),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    sync_edge #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b0)
    ) u_sync_mosi (
        .clk   (clk),
        .rst   (rst),
        .d_in  (bus.mosi),
        .level (mosi_s),
        .rise  (mosi_rise_unused),
        .fall  (mosi_fall_unused)
    );

    state_t             state_q,     state_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [SHIFT_W-1:0] shift_q,     shift_d;
    logic               head_flag_q, head_flag_d;
    logic [HEAD_W-1:0]  cmd_q,       cmd_d;
    logic [DATA_W-1:0]  data_q,      data_d;
    logic               valid_q,     valid_d;
    logic               err_q,       err_d;
    logic               busy_q,      busy_d;
    logic [SHIFT_W:0]   shifted;

    always_comb begin
        shifted     = {shift_q, mosi_s};
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        head_flag_d = head_flag_q;
        cmd_d       = cmd_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d = HEAD;
                    cnt_d   = '0;
                    shift_d = '0;
                end
            end

            HEAD: begin
                if (sck_rise) begin
                    shift_d = shifted[SHIFT_W-1:0];
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(HEAD_W - 1)) begin
                        cmd_d       = shifted[HEAD_W-1:0];
                        head_flag_d = 1'b1;
                        state_d     = DATA;
                    end
                end
                // A header that is not complete before cs rises is discarded.
                if (cs_rise) begin
                    state_d     = IDLE;
                    head_flag_d = 1'b0;
                    cmd_d       = cmd_q;
                    err_d       = 1'b1;
                end
            end

            DATA: begin
                if (sck_rise) begin
                    shift_d = shifted[SHIFT_W-1:0];
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(FRAME_W - 1)) begin
                        data_d  = shifted[DATA_W-1:0];
                        valid_d = 1'b1;
                        state_d = DONE;
                    end
                end
                // cs rising together with the final bit still counts as a complete frame.
                if (cs_rise) begin
                    state_d     = IDLE;
                    head_flag_d = 1'b0;
                    err_d       = ~valid_d;
                end
            end

            DONE: begin
                if (cs_rise) begin
                    state_d     = IDLE;
                    head_flag_d = 1'b0;
                end
            end

            default: begin
                state_d     = IDLE;
                head_flag_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            head_flag_q <= 1'b0;
            cmd_q       <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            head_flag_q <= head_flag_d;
            cmd_q       <= cmd_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.head_flag  = head_flag_q;
    assign bus.cmd_out    = cmd_q;
    assign bus.data_out   = data_q;
    assign bus.data_valid = valid_q;
    assign bus.frame_err  = err_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_spi_s2p.sv
// Directed bench for spi_s2p: a vector table of whole frames plus hand-written
// sequences for header timing, simultaneous cs/sck edges, idle noise and reset.
module tb_spi_s2p;
    import spi_pkg::*;

    localparam int HW = 2;
    localparam int DW = 14;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    spi_s2p_if #(.HEAD_W(HW), .DATA_W(DW)) bus ();

    spi_s2p #(
        .HEAD_W      (HW),
        .DATA_W      (DW),
        .SYNC_STAGES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks    = 0;
    int errors    = 0;
    int valid_cnt = 0;
    int err_cnt   = 0;

    always @(negedge clk) begin
        if (bus.data_valid === 1'b1) valid_cnt <= valid_cnt + 1;
        if (bus.frame_err === 1'b1)  err_cnt   <= err_cnt + 1;
    end

    typedef struct {
        logic [1:0]  cmd;
        logic [13:0] data;
        int          nbits;
        logic [1:0]  exp_cmd;
        logic [13:0] exp_data;
        int          exp_valid;
        int          exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        bus.mosi = b;
        wait_clk(4);
        bus.sck = 1'b1;
        wait_clk(4);
        bus.sck = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // One full cs-low window: nbits sck pulses MSB first, extra bits beyond the frame are 0.
    task automatic applyStimulus(input logic [1:0] cmd, input logic [13:0] data,
                                 input int nbits);
        logic [FRAME_W_DEF-1:0] word;
        word = {cmd, data};
        bus.cs = 1'b0;
        wait_clk(4);
        for (int i = 0; i < nbits; i++) begin
            send_bit((i < FRAME_W_DEF) ? word[FRAME_W_DEF-1-i] : 1'b0);
        end
        wait_clk(4);
        bus.cs = 1'b1;
        wait_clk(16);
    endtask

    initial begin
        int v0;
        int e0;
        logic noisy;
        logic [15:0] word;

        vecs[0] = '{2'b10, 14'h2A5C, 16, 2'b10, 14'h2A5C, 1, 0};
        vecs[1] = '{2'b01, 14'h1555,  9, 2'b01, 14'h2A5C, 0, 1};
        vecs[2] = '{2'b11, 14'h0000,  1, 2'b01, 14'h2A5C, 0, 1};
        vecs[3] = '{2'b00, 14'h3FFF, 20, 2'b00, 14'h3FFF, 1, 0};
        vecs[4] = '{2'b01, 14'h0001, 16, 2'b01, 14'h0001, 1, 0};
        vecs[5] = '{2'b11, 14'h1000, 16, 2'b11, 14'h1000, 1, 0};

        rst      = 1'b1;
        bus.sck  = 1'b0;
        bus.cs   = 1'b1;
        bus.mosi = 1'b0;
        wait_clk(3);
        checkOutput("reset_busy",       32'(bus.busy),       32'd0);
        checkOutput("reset_head_flag",  32'(bus.head_flag),  32'd0);
        checkOutput("reset_cmd_out",    32'(bus.cmd_out),    32'd0);
        checkOutput("reset_data_out",   32'(bus.data_out),   32'd0);
        checkOutput("reset_data_valid", 32'(bus.data_valid), 32'd0);
        checkOutput("reset_frame_err",  32'(bus.frame_err),  32'd0);
        rst = 1'b0;
        wait_clk(4);
        checkOutput("post_reset_busy", 32'(bus.busy), 32'd0);

        // Header timing: head_flag and cmd_out appear right after the 2nd sck rise.
        v0 = valid_cnt;
        e0 = err_cnt;
        word = {2'b10, 14'h2A5C};
        bus.cs = 1'b0;
        wait_clk(4);
        send_bit(word[15]);
        checkOutput("hdr_bit0_head_flag", 32'(bus.head_flag), 32'd0);
        checkOutput("hdr_bit0_busy",      32'(bus.busy),      32'd1);
        send_bit(word[14]);
        checkOutput("hdr_bit1_head_flag", 32'(bus.head_flag), 32'd1);
        checkOutput("hdr_bit1_cmd_out",   32'(bus.cmd_out),   32'h2);
        for (int i = 13; i >= 0; i--) send_bit(word[i]);
        wait_clk(4);
        checkOutput("done_head_flag", 32'(bus.head_flag), 32'd1);
        checkOutput("done_data_out",  32'(bus.data_out),  32'h2A5C);
        checkOutput("done_valid_cnt", 32'(valid_cnt - v0), 32'd1);
        bus.cs = 1'b1;
        wait_clk(16);
        checkOutput("end_head_flag", 32'(bus.head_flag), 32'd0);
        checkOutput("end_busy",      32'(bus.busy),      32'd0);
        checkOutput("end_err_cnt",   32'(err_cnt - e0),  32'd0);

        for (int k = 0; k < 6; k++) begin
            v0 = valid_cnt;
            e0 = err_cnt;
            applyStimulus(vecs[k].cmd, vecs[k].data, vecs[k].nbits);
            checkOutput($sformatf("vec%0d_valid_cnt", k), 32'(valid_cnt - v0), 32'(vecs[k].exp_valid));
            checkOutput($sformatf("vec%0d_err_cnt", k),   32'(err_cnt - e0),   32'(vecs[k].exp_err));
            checkOutput($sformatf("vec%0d_data_out", k),  32'(bus.data_out),   32'(vecs[k].exp_data));
            checkOutput($sformatf("vec%0d_cmd_out", k),   32'(bus.cmd_out),    32'(vecs[k].exp_cmd));
            checkOutput($sformatf("vec%0d_head_flag", k), 32'(bus.head_flag),  32'd0);
            checkOutput($sformatf("vec%0d_busy", k),      32'(bus.busy),       32'd0);
        end

        // Idle noise: sck/mosi activity with cs high must not disturb anything.
        v0 = valid_cnt;
        e0 = err_cnt;
        noisy = 1'b0;
        for (int i = 0; i < 24; i++) begin
            bus.mosi = i[1];
            bus.sck  = ~bus.sck;
            for (int j = 0; j < 3; j++) begin
                wait_clk(1);
                noisy = noisy | bus.busy | bus.head_flag;
            end
        end
        bus.sck = 1'b0;
        wait_clk(8);
        checkOutput("noise_busy_or_head", 32'(noisy),          32'd0);
        checkOutput("noise_valid_cnt",    32'(valid_cnt - v0), 32'd0);
        checkOutput("noise_err_cnt",      32'(err_cnt - e0),   32'd0);

        // cs rises in the same cycle as the final sck rise: complete frame, no error.
        v0 = valid_cnt;
        e0 = err_cnt;
        word = {2'b10, 14'h0AAB};
        bus.cs = 1'b0;
        wait_clk(4);
        for (int i = 15; i >= 1; i--) send_bit(word[i]);
        bus.mosi = word[0];
        wait_clk(4);
        bus.sck = 1'b1;
        bus.cs  = 1'b1;
        wait_clk(4);
        bus.sck = 1'b0;
        wait_clk(16);
        checkOutput("simul_valid_cnt", 32'(valid_cnt - v0), 32'd1);
        checkOutput("simul_err_cnt",   32'(err_cnt - e0),   32'd0);
        checkOutput("simul_data_out",  32'(bus.data_out),   32'h0AAB);
        checkOutput("simul_cmd_out",   32'(bus.cmd_out),    32'h2);
        checkOutput("simul_busy",      32'(bus.busy),       32'd0);
        checkOutput("simul_head_flag", 32'(bus.head_flag),  32'd0);

        // Reset after 10 bits of a frame clears everything at once with no pulse.
        v0 = valid_cnt;
        e0 = err_cnt;
        word = {2'b01, 14'h0F0F};
        bus.cs = 1'b0;
        wait_clk(4);
        for (int i = 15; i >= 6; i--) send_bit(word[i]);
        wait_clk(1);
        checkOutput("pre_rst_head_flag", 32'(bus.head_flag), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_head_flag", 32'(bus.head_flag), 32'd0);
        checkOutput("mid_rst_busy",      32'(bus.busy),      32'd0);
        checkOutput("mid_rst_cmd_out",   32'(bus.cmd_out),   32'd0);
        checkOutput("mid_rst_data_out",  32'(bus.data_out),  32'd0);
        bus.cs = 1'b1;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(6);
        checkOutput("mid_rst_valid_cnt", 32'(valid_cnt - v0), 32'd0);
        checkOutput("mid_rst_err_cnt",   32'(err_cnt - e0),   32'd0);
        checkOutput("mid_rst_busy_after", 32'(bus.busy),      32'd0);

        v0 = valid_cnt;
        applyStimulus(2'b01, 14'h1234, 16);
        checkOutput("after_rst_valid_cnt", 32'(valid_cnt - v0), 32'd1);
        checkOutput("after_rst_data_out",  32'(bus.data_out),   32'h1234);
        checkOutput("after_rst_cmd_out",   32'(bus.cmd_out),    32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
